// File: rtl/rtc_poller_pkg.sv
// Shared types and constants for the RTC capture poller: FSM states, RTC register map, data width.
package rtc_poller_pkg;

    localparam int DATA_W = 32;

    localparam logic [15:0] RTC_ADDR_CAPTURE = 16'h0100;
    localparam logic [15:0] RTC_ADDR_ARM     = 16'h0200;
    localparam logic [15:0] RTC_ADDR_STATUS  = 16'h0300;

    localparam logic [DATA_W-1:0] ARM_WORD = 32'h0000_0001;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        POLL,
        CAPTURE,
        PUSH
    } poll_state_t;

endpackage

// File: rtl/rtc_capture_poller_fifo.sv
// Synchronous show-ahead timestamp FIFO; head reads as zero while empty.
module ts_fifo
    import rtc_poller_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = DATA_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A pop frees the slot the same cycle, so a full FIFO still accepts a push alongside it.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/rtc_capture_poller.sv
// Avalon-MM master running the RTC arm -> poll -> capture loop into a timestamp FIFO.
// Build macro RTC_POLL_DELTA_EN: push capture-to-capture deltas instead of absolute timestamps.
//   state   | meaning
//   IDLE    | waiting for run
//   ARM     | writing ARM_WORD to the arm register
//   POLL    | reading status until bit 0 is set or the poll window expires
//   CAPTURE | reading the captured timestamp
//   PUSH    | one cycle: store the latched value (or drop it when full)
module rtc_capture_poller
    import rtc_poller_pkg::*;
#(
    parameter int          FIFO_DEPTH   = 16,
    parameter int unsigned POLL_TIMEOUT = 50_000,
    parameter logic [15:0] ADDR_STATUS  = RTC_ADDR_STATUS,
    parameter logic [15:0] ADDR_ARM     = RTC_ADDR_ARM,
    parameter logic [15:0] ADDR_CAPTURE = RTC_ADDR_CAPTURE
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    output logic [15:0]       avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest,
    output logic [DATA_W-1:0] ts_data,
    output logic              ts_valid,
    input  logic              ts_ready,
    output logic              overflow,
    output logic [15:0]       timeout_cnt,
    output logic              busy
);

    poll_state_t       state;
    poll_state_t       state_n;
    logic [15:0]       addr_n;
    logic              read_n;
    logic              write_n;
    logic [DATA_W-1:0] wdata_n;
    logic              poll_clr;
    logic              timeout_hit;
    logic              cap_load;
    logic              timeout_due;
    logic [31:0]       poll_cnt;
    logic [DATA_W-1:0] push_data;
    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;
    logic              drop;

    assign timeout_due = (POLL_TIMEOUT != 0) && (poll_cnt >= POLL_TIMEOUT);
    assign fifo_push   = (state == PUSH);
    assign drop        = fifo_push & fifo_full & ~ts_ready;
    assign busy        = (state != IDLE);
    assign ts_valid    = ~fifo_empty;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            avm_address   <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
            poll_cnt      <= '0;
            timeout_cnt   <= '0;
            overflow      <= 1'b0;
        end else begin
            state         <= state_n;
            avm_address   <= addr_n;
            avm_read      <= read_n;
            avm_write     <= write_n;
            avm_writedata <= wdata_n;
            if (poll_clr)
                poll_cnt <= '0;
            else if (state == POLL && poll_cnt != '1)
                poll_cnt <= poll_cnt + 32'd1;
            if (timeout_hit && timeout_cnt != 16'hFFFF)
                timeout_cnt <= timeout_cnt + 16'd1;
            if (drop)
                overflow <= 1'b1;
        end
    end

    // Each transfer: one cycle to raise the request, then hold it until waitrequest drops.
    always_comb begin
        state_n     = state;
        addr_n      = avm_address;
        read_n      = avm_read;
        write_n     = avm_write;
        wdata_n     = avm_writedata;
        poll_clr    = 1'b0;
        timeout_hit = 1'b0;
        cap_load    = 1'b0;
        case (state)
            IDLE: begin
                if (run) state_n = ARM;
            end
            ARM: begin
                if (!avm_write) begin
                    write_n = 1'b1;
                    addr_n  = ADDR_ARM;
                    wdata_n = ARM_WORD;
                end else if (!avm_waitrequest) begin
                    write_n  = 1'b0;
                    poll_clr = 1'b1;
                    state_n  = POLL;
                end
            end
            POLL: begin
                if (!avm_read) begin
                    if (timeout_due) begin
                        timeout_hit = 1'b1;
                        state_n     = ARM;
                    end else begin
                        read_n = 1'b1;
                        addr_n = ADDR_STATUS;
                    end
                end else if (!avm_waitrequest) begin
                    read_n = 1'b0;
                    // A set flag on the last read wins over the timeout; re-arming would discard it.
                    if (avm_readdata[0]) begin
                        state_n = CAPTURE;
                    end else if (timeout_due) begin
                        timeout_hit = 1'b1;
                        state_n     = ARM;
                    end
                end
            end
            CAPTURE: begin
                if (!avm_read) begin
                    read_n = 1'b1;
                    addr_n = ADDR_CAPTURE;
                end else if (!avm_waitrequest) begin
                    read_n   = 1'b0;
                    cap_load = 1'b1;
                    state_n  = PUSH;
                end
            end
            PUSH: begin
                state_n = run ? ARM : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef RTC_POLL_DELTA_EN
    logic [DATA_W-1:0] prev_ts;
    logic              have_prev;

    // The reference advances on every capture, even one later dropped on a full FIFO.
    always_ff @(posedge clock) begin
        if (!reset) begin
            push_data <= '0;
            prev_ts   <= '0;
            have_prev <= 1'b0;
        end else if (cap_load) begin
            push_data <= have_prev ? (avm_readdata - prev_ts) : avm_readdata;
            prev_ts   <= avm_readdata;
            have_prev <= 1'b1;
        end
    end
`else
    always_ff @(posedge clock) begin
        if (!reset)
            push_data <= '0;
        else if (cap_load)
            push_data <= avm_readdata;
    end
`endif

    ts_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (ts_ready),
        .head      (ts_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
